// File: rtl/pc_unit_pkg.sv
// Shared constants for the program-counter slice: jump selectors, FSM state
// encodings and the default boot address.
package pc_unit_pkg;

  localparam logic [1:0] JP_RELATIVE = 2'd0;
  localparam logic [1:0] JP_TO_F     = 2'd1;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_t;

  // Selector values 2 and 3 are reserved and behave as "no jump".
  function automatic logic is_valid_jump(input logic [1:0] sel);
    return (sel == JP_RELATIVE) || (sel == JP_TO_F);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-address priority mux: trap > jump > sequential > hold.
// Alignment checking of jump targets is compiled in with PC_MISALIGN_EN.
module pc_next_sel
  import pc_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int INST_BYTES = 4
) (
  input  logic [XLEN-1:0] cur_addr,
  input  logic            go_next,
  input  logic            jump,
  input  logic [1:0]      jump_sel,
  input  logic [XLEN-1:0] f_data,
  input  logic [XLEN-1:0] rel_addr,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] next_addr,
  output logic            load,
  output logic            redirect,
  output logic            step
`ifdef PC_MISALIGN_EN
  , output logic          misalign
`endif
);

  localparam logic [XLEN-1:0] INC = XLEN'(INST_BYTES);

  logic [XLEN-1:0] seq_addr;
  logic [XLEN-1:0] rel_target;
  logic [XLEN-1:0] jump_target;
  logic            bad_align;

  // Targets derive from the registered address only, so there is no loop.
  assign seq_addr    = cur_addr + INC;
  assign rel_target  = cur_addr + rel_addr;
  assign jump_target = (jump_sel == JP_TO_F) ? f_data : rel_target;

`ifdef PC_MISALIGN_EN
  assign bad_align = (jump_target[1:0] != 2'b00);
`else
  assign bad_align = 1'b0;
`endif

  always_comb begin
    next_addr = cur_addr;
    load      = 1'b0;
    redirect  = 1'b0;
    step      = 1'b0;
`ifdef PC_MISALIGN_EN
    misalign  = 1'b0;
`endif
    if (trap) begin
      next_addr = trap_vec;
      load      = 1'b1;
      redirect  = 1'b1;
    end else if (go_next) begin
      if (jump && is_valid_jump(jump_sel)) begin
        if (bad_align) begin
`ifdef PC_MISALIGN_EN
          misalign = 1'b1;
`endif
        end else begin
          next_addr = jump_target;
          load      = 1'b1;
          redirect  = 1'b1;
          step      = 1'b1;
        end
      end else begin
        next_addr = seq_addr;
        load      = 1'b1;
        step      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with BOOT/RUN/HALT control, previous-PC and retired-step
// counter. Define PC_MISALIGN_EN to reject misaligned jump targets.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEFAULT_RESET_VEC),
  parameter int              INST_BYTES = 4,
  parameter int              CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go_next,
  input  logic             jump,
  input  logic [1:0]       jump_sel,
  input  logic [XLEN-1:0]  f_data,
  input  logic [XLEN-1:0]  rel_addr,
  input  logic             trap,
  input  logic [XLEN-1:0]  trap_vec,
  input  logic             halt_req,
  input  logic             resume,
  output logic [XLEN-1:0]  inst_addr,
  output logic [XLEN-1:0]  prev_addr,
  output logic             redirect,
  output logic             halted,
  output logic [CNT_W-1:0] instret
`ifdef PC_MISALIGN_EN
  , output logic           misalign
`endif
);

  pc_state_t state_reg, state_next;

  logic            sel_go;
  logic            sel_trap;
  logic [XLEN-1:0] sel_addr;
  logic            sel_load;
  logic            sel_redirect;
  logic            sel_step;
`ifdef PC_MISALIGN_EN
  logic            sel_misalign;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_BOOT;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN:  if (!trap && halt_req) state_next = ST_HALT;
      ST_HALT: begin
        if (trap)                      state_next = ST_RUN;
        else if (resume && !halt_req)  state_next = ST_RUN;
      end
      default: state_next = ST_BOOT;
    endcase
  end

  // BOOT blocks all updates; HALT only lets a trap through to the mux.
  always_comb begin
    sel_go   = 1'b0;
    sel_trap = 1'b0;
    case (state_reg)
      ST_RUN: begin
        sel_go   = go_next;
        sel_trap = trap;
      end
      ST_HALT: sel_trap = trap;
      default: begin
        sel_go   = 1'b0;
        sel_trap = 1'b0;
      end
    endcase
  end

  assign halted = (state_reg == ST_HALT);

  pc_next_sel #(
    .XLEN      (XLEN),
    .INST_BYTES(INST_BYTES)
  ) u_next_sel (
    .cur_addr (inst_addr),
    .go_next  (sel_go),
    .jump     (jump),
    .jump_sel (jump_sel),
    .f_data   (f_data),
    .rel_addr (rel_addr),
    .trap     (sel_trap),
    .trap_vec (trap_vec),
    .next_addr(sel_addr),
    .load     (sel_load),
    .redirect (sel_redirect),
    .step     (sel_step)
`ifdef PC_MISALIGN_EN
    , .misalign(sel_misalign)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_addr <= RESET_VEC;
      prev_addr <= RESET_VEC;
      redirect  <= 1'b0;
      instret   <= '0;
    end else begin
      redirect <= sel_redirect;
      if (sel_load) begin
        inst_addr <= sel_addr;
        prev_addr <= inst_addr;
      end
      if (sel_step) instret <= instret + CNT_W'(1);
    end
  end

`ifdef PC_MISALIGN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= sel_misalign;
  end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit; covers both the default build
// and the PC_MISALIGN_EN build.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        go_next, jump, trap, halt_req, resume;
  logic [1:0]  jump_sel;
  logic [31:0] f_data, rel_addr, trap_vec;
  logic [31:0] inst_addr, prev_addr, instret;
  logic        redirect, halted;
`ifdef PC_MISALIGN_EN
  logic        misalign;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk      (clk),
    .rst      (rst),
    .go_next  (go_next),
    .jump     (jump),
    .jump_sel (jump_sel),
    .f_data   (f_data),
    .rel_addr (rel_addr),
    .trap     (trap),
    .trap_vec (trap_vec),
    .halt_req (halt_req),
    .resume   (resume),
    .inst_addr(inst_addr),
    .prev_addr(prev_addr),
    .redirect (redirect),
    .halted   (halted),
    .instret  (instret)
`ifdef PC_MISALIGN_EN
    , .misalign(misalign)
`endif
  );

  typedef struct {
    logic        go, jmp;
    logic [1:0]  sel;
    logic [31:0] fdat, rel;
    logic        trp;
    logic [31:0] tvec;
    logic        hreq, res;
    logic [31:0] e_addr, e_prev;
    logic        e_red, e_halt;
    logic [31:0] e_ir;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [31:0] ea, input logic [31:0] ep,
                             input logic er, input logic eh, input logic [31:0] ei, input logic em);
    chk({tag, ".inst_addr"}, inst_addr, ea);
    chk({tag, ".prev_addr"}, prev_addr, ep);
    chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, er});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, eh});
    chk({tag, ".instret"}, instret, ei);
`ifdef PC_MISALIGN_EN
    chk({tag, ".misalign"}, {31'd0, misalign}, {31'd0, em});
`else
    if (em !== 1'b0) $display("note %s: misalign expectation ignored in this build", tag);
`endif
  endtask

  task automatic idle_inputs();
    go_next = 1'b0; jump = 1'b0; jump_sel = 2'd0; f_data = '0; rel_addr = '0;
    trap = 1'b0; trap_vec = '0; halt_req = 1'b0; resume = 1'b0;
  endtask

  initial begin
    // go, jmp, sel, f_data, rel, trap, trap_vec, halt_req, resume | addr, prev, red, halted, instret, misalign
    vecs.push_back('{1'b1,1'b0,2'd0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b0, 32'h0,32'h0,1'b0,1'b0,32'd0,1'b0});   // BOOT holds
    vecs.push_back('{1'b1,1'b0,2'd0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b0, 32'h4,32'h0,1'b0,1'b0,32'd1,1'b0});
    vecs.push_back('{1'b1,1'b0,2'd0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b0, 32'h8,32'h4,1'b0,1'b0,32'd2,1'b0});
    vecs.push_back('{1'b1,1'b0,2'd0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b0, 32'hC,32'h8,1'b0,1'b0,32'd3,1'b0});
    vecs.push_back('{1'b1,1'b0,2'd0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b0, 32'h10,32'hC,1'b0,1'b0,32'd4,1'b0});
    vecs.push_back('{1'b1,1'b1,2'd0,32'h0,32'hFFFF_FFF8,1'b0,32'h0,1'b0,1'b0, 32'h8,32'h10,1'b1,1'b0,32'd5,1'b0}); // rel -8
    vecs.push_back('{1'b1,1'b0,2'd0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b0, 32'hC,32'h8,1'b0,1'b0,32'd6,1'b0});
    vecs.push_back('{1'b1,1'b1,2'd1,32'h40,32'h0,1'b0,32'h0,1'b0,1'b0, 32'h40,32'hC,1'b1,1'b0,32'd7,1'b0}); // absolute
    vecs.push_back('{1'b1,1'b1,2'd1,32'h40,32'h0,1'b1,32'h100,1'b0,1'b0, 32'h100,32'h40,1'b1,1'b0,32'd7,1'b0}); // trap beats jump
    vecs.push_back('{1'b0,1'b0,2'd0,32'h0,32'h0,1'b1,32'h200,1'b0,1'b0, 32'h200,32'h100,1'b1,1'b0,32'd7,1'b0}); // trap w/o go
    vecs.push_back('{1'b1,1'b1,2'd1,32'h20,32'h0,1'b0,32'h0,1'b0,1'b0, 32'h20,32'h200,1'b1,1'b0,32'd8,1'b0});
    vecs.push_back('{1'b1,1'b0,2'd0,32'h0,32'h0,1'b0,32'h0,1'b1,1'b0, 32'h24,32'h20,1'b0,1'b1,32'd9,1'b0}); // halt + step
    vecs.push_back('{1'b1,1'b1,2'd1,32'h80,32'h0,1'b0,32'h0,1'b0,1'b0, 32'h24,32'h20,1'b0,1'b1,32'd9,1'b0});
    vecs.push_back('{1'b1,1'b1,2'd1,32'h80,32'h0,1'b0,32'h0,1'b0,1'b0, 32'h24,32'h20,1'b0,1'b1,32'd9,1'b0});
    vecs.push_back('{1'b1,1'b0,2'd0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b0, 32'h24,32'h20,1'b0,1'b1,32'd9,1'b0});
    vecs.push_back('{1'b1,1'b0,2'd0,32'h0,32'h0,1'b0,32'h0,1'b1,1'b1, 32'h24,32'h20,1'b0,1'b1,32'd9,1'b0}); // both: stay
    vecs.push_back('{1'b0,1'b0,2'd0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b1, 32'h24,32'h20,1'b0,1'b0,32'd9,1'b0}); // resume
    vecs.push_back('{1'b1,1'b0,2'd0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b0, 32'h28,32'h24,1'b0,1'b0,32'd10,1'b0});
    vecs.push_back('{1'b1,1'b1,2'd2,32'h80,32'h40,1'b0,32'h0,1'b0,1'b0, 32'h2C,32'h28,1'b0,1'b0,32'd11,1'b0}); // reserved sel
    vecs.push_back('{1'b0,1'b1,2'd1,32'h80,32'h0,1'b0,32'h0,1'b0,1'b0, 32'h2C,32'h28,1'b0,1'b0,32'd11,1'b0}); // jump w/o go
    vecs.push_back('{1'b1,1'b0,2'd0,32'h0,32'h0,1'b1,32'hFFFF_FFFC,1'b1,1'b0, 32'hFFFF_FFFC,32'h2C,1'b1,1'b0,32'd11,1'b0}); // trap blocks halt
    vecs.push_back('{1'b1,1'b0,2'd0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b0, 32'h0,32'hFFFF_FFFC,1'b0,1'b0,32'd12,1'b0}); // wrap
    vecs.push_back('{1'b0,1'b0,2'd0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b0, 32'h0,32'hFFFF_FFFC,1'b0,1'b0,32'd12,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b0, 32'h0,32'hFFFF_FFFC,1'b0,1'b0,32'd12,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,32'h0,32'h0,1'b0,32'h0,1'b1,1'b0, 32'h0,32'hFFFF_FFFC,1'b0,1'b1,32'd12,1'b0}); // halt, no step
    vecs.push_back('{1'b0,1'b0,2'd0,32'h0,32'h0,1'b1,32'h300,1'b0,1'b0, 32'h300,32'h0,1'b1,1'b0,32'd12,1'b0}); // trap leaves HALT
    vecs.push_back('{1'b1,1'b1,2'd0,32'h0,32'h10,1'b0,32'h0,1'b0,1'b0, 32'h310,32'h300,1'b1,1'b0,32'd13,1'b0});
`ifdef PC_MISALIGN_EN
    vecs.push_back('{1'b1,1'b1,2'd1,32'h42,32'h0,1'b0,32'h0,1'b0,1'b0, 32'h310,32'h300,1'b0,1'b0,32'd13,1'b1}); // rejected
    vecs.push_back('{1'b1,1'b1,2'd0,32'h0,32'h6,1'b0,32'h0,1'b0,1'b0, 32'h310,32'h300,1'b0,1'b0,32'd13,1'b1});
    vecs.push_back('{1'b1,1'b0,2'd0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b0, 32'h314,32'h310,1'b0,1'b0,32'd14,1'b0});
`else
    vecs.push_back('{1'b1,1'b1,2'd1,32'h42,32'h0,1'b0,32'h0,1'b0,1'b0, 32'h42,32'h310,1'b1,1'b0,32'd14,1'b0}); // loaded as-is
    vecs.push_back('{1'b1,1'b0,2'd0,32'h0,32'h0,1'b0,32'h0,1'b0,1'b0, 32'h46,32'h42,1'b0,1'b0,32'd15,1'b0});
`endif

    rst = 1'b1;
    idle_inputs();
    #12;
    chk_outputs("reset", 32'h0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      go_next  = vecs[i].go;
      jump     = vecs[i].jmp;
      jump_sel = vecs[i].sel;
      f_data   = vecs[i].fdat;
      rel_addr = vecs[i].rel;
      trap     = vecs[i].trp;
      trap_vec = vecs[i].tvec;
      halt_req = vecs[i].hreq;
      resume   = vecs[i].res;
      @(posedge clk);
      #1;
      $display("vec %0d: addr=%h prev=%h red=%b halted=%b instret=%0d",
               i, inst_addr, prev_addr, redirect, halted, instret);
      chk_outputs($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_prev,
                  vecs[i].e_red, vecs[i].e_halt, vecs[i].e_ir, vecs[i].e_mis);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a step drops the pending update.
    idle_inputs();
    go_next = 1'b1;
    #2 rst = 1'b1;
    #1;
    $display("async reset: addr=%h instret=%0d", inst_addr, instret);
    chk_outputs("async_rst", 32'h0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    $display("reset held: addr=%h instret=%0d", inst_addr, instret);
    chk("rst_held.inst_addr", inst_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("reboot: addr=%h instret=%0d", inst_addr, instret);
    chk("reboot_boot.inst_addr", inst_addr, 32'h0);
    chk("reboot_boot.instret", instret, 32'd0);
    @(posedge clk);
    #1;
    $display("reboot step: addr=%h instret=%0d", inst_addr, instret);
    chk("reboot_step.inst_addr", inst_addr, 32'h4);
    chk("reboot_step.instret", instret, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
